// File: rtl/sbqm_people_counter.sv
// Bank-queue customer counter: filters entry/exit photocells, keeps PCount.
// Ports: clk, rst; entry_sensor, exit_sensor in; PCount, full, empty, count_upd, ovf_err, udf_err out.
module sbqm_people_counter #(
    parameter int DEB_CYCLES = 4,
    parameter int MAX_COUNT  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    output logic [2:0] PCount,
    output logic       full,
    output logic       empty,
    output logic       count_upd,
    output logic       ovf_err,
    output logic       udf_err
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [2:0] MAX_C = 3'(MAX_COUNT);

    // Bit 0 is the entry path, bit 1 the exit path.
    logic [1:0] raw;
    logic [1:0] s1_q, s1_d;
    logic [1:0] s2_q, s2_d;
    logic [1:0] filt_q, filt_d;
    logic [1:0] filt_dly_q, filt_dly_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0] evt;

    logic [2:0] pcount_q, pcount_d;
    logic       full_q, full_d;
    logic       empty_q, empty_d;
    logic       upd_q, upd_d;
    logic       ovf_q, ovf_d;
    logic       udf_q, udf_d;

    assign raw = {exit_sensor, entry_sensor};

    // Synchroniser and debounce: the filtered level only follows the
    // synchronised level after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        s1_d       = raw;
        s2_d       = s1_q;
        filt_d     = filt_q;
        filt_dly_d = filt_q;
        cnt_d      = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // One event per beam break: rising edge of the filtered level only.
    assign evt = filt_q & ~filt_dly_q;

    // Saturation is checked before the add/subtract, so no wrap is possible.
    // Simultaneous entry and exit cancel out without touching the flags.
    always_comb begin
        pcount_d = pcount_q;
        upd_d    = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (evt == 2'b01) begin
            if (pcount_q < MAX_C) begin
                pcount_d = pcount_q + 3'd1;
                upd_d    = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (evt == 2'b10) begin
            if (pcount_q != 3'd0) begin
                pcount_d = pcount_q - 3'd1;
                upd_d    = 1'b1;
            end else begin
                udf_d = 1'b1;
            end
        end
        full_d  = (pcount_d == MAX_C);
        empty_d = (pcount_d == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            filt_q     <= '0;
            filt_dly_q <= '0;
            cnt_q      <= '0;
            pcount_q   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            upd_q      <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
            cnt_q      <= cnt_d;
            pcount_q   <= pcount_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            upd_q      <= upd_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign PCount    = pcount_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count_upd = upd_q;
    assign ovf_err   = ovf_q;
    assign udf_err   = udf_q;

endmodule

// File: tb/tb_sbqm_people_counter.sv
// Bench for sbqm_people_counter: directed plan plus random sensor traffic.
// A sample-window reference model predicts every output on every cycle.
module tb_sbqm_people_counter;

    localparam int DEB  = 4;
    localparam int MAXC = 7;

    logic       clk;
    logic       rst;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [2:0] PCount;
    logic       full;
    logic       empty;
    logic       count_upd;
    logic       ovf_err;
    logic       udf_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pc;
    bit m_upd, m_ovf, m_udf;
    bit m_f0, m_f1;
    bit m_e0, m_e1;
    bit hq0[$];
    bit hq1[$];

    sbqm_people_counter #(
        .DEB_CYCLES(DEB),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .entry_sensor(entry_sensor),
        .exit_sensor (exit_sensor),
        .PCount      (PCount),
        .full        (full),
        .empty       (empty),
        .count_upd   (count_upd),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // True when the DEB raw samples that reach the filter this edge
    // (taken 2..DEB+1 edges ago) all disagree with the filtered level.
    function automatic bit all_differ(input bit q[$], input bit f);
        for (int i = q.size() - 1 - DEB; i <= q.size() - 2; i++)
            if (q[i] == f) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit r, input bit en, input bit ex);
        bit nf0, nf1;
        if (r) begin
            m_pc = 0; m_upd = 0; m_ovf = 0; m_udf = 0;
            m_f0 = 0; m_f1 = 0; m_e0 = 0; m_e1 = 0;
            hq0.delete();
            hq1.delete();
            repeat (DEB + 2) begin
                hq0.push_back(1'b0);
                hq1.push_back(1'b0);
            end
        end else begin
            m_upd = 0;
            if (m_e0 && !m_e1) begin
                if (m_pc < MAXC) begin m_pc++; m_upd = 1; end
                else m_ovf = 1;
            end else if (m_e1 && !m_e0) begin
                if (m_pc > 0) begin m_pc--; m_upd = 1; end
                else m_udf = 1;
            end
            nf0 = all_differ(hq0, m_f0) ? !m_f0 : m_f0;
            nf1 = all_differ(hq1, m_f1) ? !m_f1 : m_f1;
            m_e0 = nf0 && !m_f0;
            m_e1 = nf1 && !m_f1;
            m_f0 = nf0;
            m_f1 = nf1;
            hq0.push_back(en);
            hq1.push_back(ex);
            void'(hq0.pop_front());
            void'(hq1.pop_front());
        end
    endtask

    task automatic step(input bit r, input bit en, input bit ex);
        rst = r;
        entry_sensor = en;
        exit_sensor = ex;
        @(posedge clk);
        model_edge(r, en, ex);
        @(negedge clk);
        chk("pcount", 8'(PCount), 8'(m_pc));
        chk("full", 8'(full), 8'(m_pc == MAXC));
        chk("empty", 8'(empty), 8'(m_pc == 0));
        chk("count_upd", 8'(count_upd), 8'(m_upd));
        chk("ovf_err", 8'(ovf_err), 8'(m_ovf));
        chk("udf_err", 8'(udf_err), 8'(m_udf));
    endtask

    task automatic pulse(input bit en, input bit ex, input int hi, input int lo);
        repeat (hi) step(1'b0, en, ex);
        repeat (lo) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int lat;
        int en_left, ex_left;
        bit en_lvl, ex_lvl, r;
        clk = 1'b0;

        // Reset for two cycles, then idle
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("rst_pcount", 8'(PCount), 8'd0);
        chk("rst_empty", 8'(empty), 8'd1);
        chk("rst_full", 8'(full), 8'd0);
        chk("rst_upd", 8'(count_upd), 8'd0);
        chk("rst_errs", 8'({ovf_err, udf_err}), 8'd0);

        // First entry: measure latency from the first high sample edge
        lat = -1;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, i < 6, 1'b0);
            if (lat < 0 && PCount == 3'd1) lat = i;
        end
        chk("ent_latency", 8'(lat), 8'(DEB + 2));
        chk("ent_empty", 8'(empty), 8'd0);

        // Six more entries to reach full
        repeat (6) pulse(1'b1, 1'b0, 6, 8);
        chk("full_pcount", 8'(PCount), 8'd7);
        chk("full_flag", 8'(full), 8'd1);

        // Overflow then one exit
        pulse(1'b1, 1'b0, 6, 8);
        chk("ovf_pcount", 8'(PCount), 8'd7);
        chk("ovf_flag", 8'(ovf_err), 8'd1);
        pulse(1'b0, 1'b1, 6, 8);
        chk("exit_pcount", 8'(PCount), 8'd6);
        chk("exit_full", 8'(full), 8'd0);
        chk("ovf_sticky", 8'(ovf_err), 8'd1);

        // Short glitch is ignored
        pulse(1'b1, 1'b0, DEB - 1, 10);
        chk("glitch_pcount", 8'(PCount), 8'd6);

        // Drain, then underflow, then simultaneous entry/exit at zero
        repeat (6) pulse(1'b0, 1'b1, 6, 8);
        chk("drain_pcount", 8'(PCount), 8'd0);
        pulse(1'b0, 1'b1, 6, 8);
        chk("udf_flag", 8'(udf_err), 8'd1);
        chk("udf_pcount", 8'(PCount), 8'd0);
        pulse(1'b1, 1'b1, 6, 8);
        chk("both_pcount", 8'(PCount), 8'd0);

        // Reset mid-debounce with entry held through release
        repeat (3) pulse(1'b1, 1'b0, 6, 8);
        chk("pre_rst_pcount", 8'(PCount), 8'd3);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b0);
        chk("midrst_pcount", 8'(PCount), 8'd0);
        chk("midrst_errs", 8'({ovf_err, udf_err}), 8'd0);
        lat = -1;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, i < 10, 1'b0);
            if (lat < 0 && PCount == 3'd1) lat = i;
        end
        chk("rel_latency", 8'(lat), 8'(DEB + 2));

        // Random sensor traffic with occasional reset
        en_left = 0;
        ex_left = 0;
        en_lvl = 0;
        ex_lvl = 0;
        for (int n = 0; n < 1500; n++) begin
            if (en_left == 0) begin
                en_lvl = 1'($urandom % 2);
                en_left = $urandom_range(1, 10);
            end
            if (ex_left == 0) begin
                ex_lvl = 1'($urandom % 2);
                ex_left = $urandom_range(1, 10);
            end
            r = ($urandom % 80) == 0;
            step(r, en_lvl, ex_lvl);
            en_left--;
            ex_left--;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
